lsu_access_sequencer: RTL and testbench
=======================================

Name: lsu_access_sequencer

Overview:
- Multi-cycle load/store sequencer between the pipeline and the data memory port.
- Consumes the decoded memory controls from the main control unit: MemRead, the MemWrite byte pattern, MemReadSize and MemReadSigned.
- Drives a req/ack word-wide memory handshake. Converts byte/half accesses into lane-aligned word transfers.
- Splits accesses that cross a word boundary into two transfers; returns an aligned, extended load result. The pipeline holds on busy.

Parameters:
ADDR_W, 32, byte address width; memory address is word-aligned (bits [1:0] driven 0).

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
req_valid  input  1  pipeline presents a memory op this cycle
mem_read  input  1  MemRead from decode
mem_write  input  4  MemWrite pattern from decode: 0000 none, 0001 SB, 0011 SH, 1111 SW
read_size  input  2  MemReadSize: 0 byte, 1 half, 2 word
read_signed  input  1  MemReadSigned
addr  input  ADDR_W  byte address (ALU result)
wdata  input  32  store data, right-justified
busy  output  1  high when state != IDLE; pipeline stalls
done  output  1  one-cycle pulse, operation complete
err  output  1  one-cycle pulse coincident with done, illegal or unsupported op
rdata  output  32  extended load result, valid when done && mem_read op
mem_req  output  1  memory request
mem_we  output  1  write request
mem_be  output  4  byte enables for current word
mem_addr  output  ADDR_W  word-aligned address
mem_wdata  output  32  lane-shifted write data
mem_ack  input  1  memory accepts/completes current request this cycle
mem_rdata  input  32  read word, valid with mem_ack

Behaviour:
- Reset values:
  - state IDLE.
  - busy, done, err, mem_req, mem_we are 0.
  - mem_be = 0000, mem_addr = 0, mem_wdata = 0, rdata = 0.
  - rst mid-operation abandons the transfer immediately; the next cycle is IDLE with mem_req 0.
- States are IDLE, ACC0, ACC1, FIN.
- IDLE:
  - Accepts when req_valid && (mem_read || mem_write != 0). Captures all inputs; no other input is sampled later.
  - req_valid with no op is ignored. Inputs while busy are ignored.
- Legality:
  - Illegal when mem_read && mem_write != 0.
  - Illegal when the mem_write pattern is not in {0001, 0011, 1111}.
  - Illegal when a read has read_size = 3.
  - Illegal accept goes to FIN directly with err = 1. No memory transaction occurs.
- Lane math, with off = addr[1:0]:
  - be64 = pattern << off. For loads, pattern is 0001, 0011 or 1111 by read_size.
  - wd64 = {32'b0, wdata} << (8*off).
  - Word 0 uses mem_addr = {addr[ADDR_W-1:2], 2'b00}, mem_be = be64[3:0], mem_wdata = wd64[31:0].
  - Word 1 uses mem_addr = word 0 address + 4 (wraps modulo 2^ADDR_W), mem_be = be64[7:4], mem_wdata = wd64[63:32].
  - Split is required iff be64[7:4] != 0.
- ACC0:
  - mem_req = 1; mem_we = store.
  - addr, be and wdata are held stable until mem_ack.
  - On mem_ack: a load latches mem_rdata into the low word buffer. Next state is ACC1 if split, else FIN.
- ACC1:
  - Same handshake with word 1.
  - On mem_ack: a load latches the high word buffer. Next state is FIN.
- mem_ack is sampled only while mem_req = 1, and may arrive the same cycle as mem_req (zero-wait). mem_ack outside a request is ignored.
- FIN:
  - done = 1 and mem_req = 0. Next state is IDLE, so busy drops the cycle after done.
  - Load result: r64 = {hi, lo} >> (8*off). rdata takes r64[7:0], r64[15:0] or r64[31:0] by size, then sign- or zero-extends per read_signed. Word loads ignore read_signed.
  - Stores leave rdata unchanged.
- Latency with accept at cycle N:
  - mem_req is high from N+1.
  - Aligned access with zero-wait ack gives done at N+2.
  - Split access with zero-wait acks gives done at N+3.
  - Each wait cycle adds one.
- Back-to-back: a new accept is possible the cycle after FIN.

Optional Feature:
- LSU_MISALIGN_SPLIT_EN defined: split behaviour as above.
- Not defined:
  - Any access needing a split, or any non-naturally-aligned half or word, is illegal.
  - Such an access goes to FIN with err = 1 and performs no memory transaction.
  - The ACC1 state and high word buffer are not built.

Test Plan:
- Aligned SW: addr 0x100, wdata 0xDEADBEEF, ack zero-wait -> mem_addr 0x100, be 1111, mem_wdata 0xDEADBEEF at N+1; done at N+2; busy high N+1..N+2.
- LB signed: addr 0x203, mem_rdata 0x80FFFFFF, ack after 2 wait cycles -> mem_be 1000, mem_addr 0x200, mem_req held 3 cycles, rdata 0xFFFFFF80.
- LHU split (SPLIT_EN): addr 0x0FF, word0 rdata 0xAB000000, word1 rdata 0x000000CD -> be 1000 @0x0FC, then be 0001 @0x100, rdata 0x0000CDAB, done at N+3.
- SH split store (SPLIT_EN): addr 0x13, wdata 0x1234 -> word0 @0x10 be 1000 wdata 0x34000000; word1 @0x14 be 0001 wdata 0x00000012.
- Illegal ops: mem_read = 1 with mem_write = 0011; then read_size = 3; also LW addr 0x2 without SPLIT_EN -> each: mem_req stays 0, done and err pulse at N+1.
- Reset mid-op: rst during ACC0 with ack withheld -> next cycle mem_req 0, busy 0, no done; a subsequent LW @0x40 completes normally.

Source files
------------

// File: rtl/lsu_access_sequencer_if.sv
// Word-wide req/ack data memory port driven by the load/store sequencer.
interface lsu_access_sequencer_if #(
  parameter int unsigned ADDR_W = 32
) ();
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;

  logic              mem_req;
  logic              mem_we;
  logic [BE_W-1:0]   mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/lsu_access_sequencer.sv
// Load/store sequencer: turns decoded byte/half/word memory ops into lane-aligned
// word transfers on a req/ack port and returns an aligned, extended load result.
// Build option LSU_MISALIGN_SPLIT_EN: when defined, accesses crossing a word
// boundary are split into two transfers; when undefined, such accesses and any
// non-naturally-aligned half/word are rejected with err and no memory traffic.
module lsu_access_sequencer #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  input  logic                   mem_read,
  input  logic [3:0]             mem_write,
  input  logic [1:0]             read_size,
  input  logic                   read_signed,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [31:0]            wdata,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [31:0]            rdata,
  lsu_access_sequencer_if.master mem
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, FIN} state_t;

  state_t            state_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [BE_W-1:0]   mem_be_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  // Operation context captured at accept
  logic              is_load_q;
  logic [1:0]        size_q;
  logic              signed_q;
  logic [1:0]        off_q;

  logic              is_store_c;
  logic              accept_c;
  logic              illegal_c;
  logic [1:0]        off_c;
  logic [BE_W-1:0]   rd_pat_c;
  logic [BE_W-1:0]   pat_c;
  logic [2*BE_W-1:0] be64_c;
  logic              split_c;
  logic [ADDR_W-1:0] word0_c;
  logic [DATA_W-1:0] wd_lo_c;
  logic [DATA_W-1:0] shifted_c;
  logic [DATA_W-1:0] ld_ext_c;

`ifdef LSU_MISALIGN_SPLIT_EN
  logic              split_q;
  logic [BE_W-1:0]   be_hi_q;
  logic [DATA_W-1:0] wd_hi_q;
  logic [DATA_W-1:0] lo_q;
  logic [DATA_W-1:0] wd_hi_c;
  logic [DATA_W-1:0] lo_src_c;
  logic [DATA_W-1:0] hi_src_c;
`endif

  // Decode the incoming op: acceptance, legality and lane placement of word 0/1
  always_comb begin
    is_store_c = (mem_write != 4'b0000);
    accept_c   = req_valid && (mem_read || is_store_c);
    off_c      = addr[1:0];
    unique case (read_size)
      2'd0:    rd_pat_c = 4'b0001;
      2'd1:    rd_pat_c = 4'b0011;
      2'd2:    rd_pat_c = 4'b1111;
      default: rd_pat_c = 4'b0000;
    endcase
    pat_c     = mem_read ? rd_pat_c : mem_write;
    be64_c    = {4'b0000, pat_c} << off_c;
    split_c   = (be64_c[7:4] != 4'b0000);
    illegal_c = (mem_read && is_store_c)
             || (is_store_c && !(mem_write inside {4'b0001, 4'b0011, 4'b1111}))
             || (mem_read && (read_size == 2'd3));
`ifdef LSU_MISALIGN_SPLIT_EN
    {wd_hi_c, wd_lo_c} = {32'b0, wdata} << {off_c, 3'b000};
`else
    wd_lo_c   = wdata << {off_c, 3'b000};
    // Without splitting, only naturally aligned accesses are serviceable
    illegal_c = illegal_c || split_c
             || ((pat_c == 4'b0011) && off_c[0])
             || ((pat_c == 4'b1111) && (off_c != 2'b00));
`endif
    word0_c   = {addr[ADDR_W-1:2], 2'b00};
  end

  // Align and extend the load result; the final word is taken straight off the bus
  always_comb begin
`ifdef LSU_MISALIGN_SPLIT_EN
    lo_src_c  = (state_q == ACC0) ? mem.mem_rdata : lo_q;
    hi_src_c  = (state_q == ACC1) ? mem.mem_rdata : 32'b0;
    shifted_c = 32'({hi_src_c, lo_src_c} >> {off_q, 3'b000});
`else
    shifted_c = mem.mem_rdata >> {off_q, 3'b000};
`endif
    unique case (size_q)
      2'd0:    ld_ext_c = {{24{signed_q & shifted_c[7]}}, shifted_c[7:0]};
      2'd1:    ld_ext_c = {{16{signed_q & shifted_c[15]}}, shifted_c[15:0]};
      default: ld_ext_c = shifted_c;
    endcase
  end

  // Sequencer FSM with registered handshake and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      is_load_q   <= 1'b0;
      size_q      <= 2'd0;
      signed_q    <= 1'b0;
      off_q       <= 2'd0;
`ifdef LSU_MISALIGN_SPLIT_EN
      split_q     <= 1'b0;
      be_hi_q     <= '0;
      wd_hi_q     <= '0;
      lo_q        <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept_c) begin
            busy_q    <= 1'b1;
            is_load_q <= mem_read;
            size_q    <= read_size;
            signed_q  <= read_signed;
            off_q     <= off_c;
            if (illegal_c) begin
              state_q <= FIN;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q     <= ACC0;
              mem_req_q   <= 1'b1;
              mem_we_q    <= is_store_c;
              mem_be_q    <= be64_c[3:0];
              mem_addr_q  <= word0_c;
              mem_wdata_q <= wd_lo_c;
`ifdef LSU_MISALIGN_SPLIT_EN
              split_q     <= split_c;
              be_hi_q     <= be64_c[7:4];
              wd_hi_q     <= wd_hi_c;
`endif
            end
          end
        end
        ACC0: begin
          if (mem.mem_ack) begin
`ifdef LSU_MISALIGN_SPLIT_EN
            if (is_load_q) lo_q <= mem.mem_rdata;
            if (split_q) begin
              state_q     <= ACC1;
              mem_be_q    <= be_hi_q;
              mem_addr_q  <= mem_addr_q + ADDR_W'(4);
              mem_wdata_q <= wd_hi_q;
            end else begin
              state_q   <= FIN;
              mem_req_q <= 1'b0;
              mem_we_q  <= 1'b0;
              done_q    <= 1'b1;
              if (is_load_q) rdata_q <= ld_ext_c;
            end
`else
            state_q   <= FIN;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            done_q    <= 1'b1;
            if (is_load_q) rdata_q <= ld_ext_c;
`endif
          end
        end
        ACC1: begin
`ifdef LSU_MISALIGN_SPLIT_EN
          if (mem.mem_ack) begin
            state_q   <= FIN;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            done_q    <= 1'b1;
            if (is_load_q) rdata_q <= ld_ext_c;
          end
`else
          state_q   <= IDLE;
          busy_q    <= 1'b0;
          mem_req_q <= 1'b0;
`endif
        end
        FIN: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign rdata         = rdata_q;
  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_be    = mem_be_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_access_sequencer.sv
// Scoreboard bench for lsu_access_sequencer: a byte-level memory model predicts
// bus transfers and results; a memory responder and done monitor check them.
module tb_lsu_access_sequencer;
  localparam int unsigned ADDR_W = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        mem_read;
  logic [3:0]  mem_write;
  logic [1:0]  read_size;
  logic        read_signed;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;

  lsu_access_sequencer_if #(.ADDR_W(ADDR_W)) mem_if ();

  lsu_access_sequencer #(.ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .read_size   (read_size),
    .read_signed (read_signed),
    .addr        (addr),
    .wdata       (wdata),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .rdata       (rdata),
    .mem         (mem_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          err;
    bit          chk_rd;
    logic [31:0] rdata;
    int          acc_cyc;
    int          nwords;
    int          w_base;
    int          a_base;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [3:0]  be;
    bit          we;
    logic [31:0] wd;
  } txn_t;

  res_t res_q[$];
  txn_t txn_q[$];

  logic [31:0] resp_mem [logic [31:0]];
  logic [7:0]  ref_mem  [logic [31:0]];
  logic [31:0] last_rd = '0;

  int checks = 0;
  int failures = 0;
  int tot_waits = 0;
  int tot_acks = 0;
  int force_waits = -1;
  bit hold_ack = 1'b0;
  logic [31:0] obs_rdata = '0;
  bit obs_err = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] wa);
    return (wa * 32'h9E3779B1) ^ 32'h5BD1E995;
  endfunction

  function automatic logic [31:0] rd_word(input logic [31:0] wa);
    return resp_mem.exists(wa) ? resp_mem[wa] : init_word(wa);
  endfunction

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    logic [31:0] w;
    if (ref_mem.exists(a)) return ref_mem[a];
    w = init_word(a & ~32'h3);
    return w[8*a[1:0] +: 8];
  endfunction

  task automatic preload(input logic [31:0] wa, input logic [31:0] v);
    resp_mem[wa] = v;
    for (int i = 0; i < 4; i++) ref_mem[wa + 32'(i)] = v[8*i +: 8];
  endtask

  // Reference model: bytes touched are addr..addr+n-1, little endian
  task automatic model(input bit rd, input logic [3:0] wr, input logic [1:0] sz, input bit sg,
                       input logic [31:0] a, input logic [31:0] wd, output res_t r);
    int n;
    int off;
    bit ill;
    txn_t t;
    logic [31:0] v;
    n   = rd ? ((sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0)
             : ((wr == 4'h1) ? 1 : (wr == 4'h3) ? 2 : (wr == 4'hF) ? 4 : 0);
    off = int'(a[1:0]);
    ill = (rd && wr != 4'h0) || (n == 0);
`ifndef LSU_MISALIGN_SPLIT_EN
    if (n != 0 && (off % n) != 0) ill = 1'b1;
`endif
    r.err = ill; r.chk_rd = 1'b0; r.rdata = '0; r.nwords = 0;
    r.acc_cyc = cyc; r.w_base = tot_waits; r.a_base = tot_acks;
    if (!ill) begin
      r.nwords = (off + n > 4) ? 2 : 1;
      for (int w = 0; w < r.nwords; w++) begin
        t.a = (a & ~32'h3) + 32'(4 * w);
        t.be = '0; t.wd = '0; t.we = !rd;
        for (int p = 4 * w; p < 4 * w + 4; p++) begin
          if (p >= off && p < off + n) t.be[p - 4 * w] = 1'b1;
          if (p >= off && p < off + 4) t.wd[8 * (p - 4 * w) +: 8] = wd[8 * (p - off) +: 8];
        end
        txn_q.push_back(t);
      end
      if (rd) begin
        v = '0;
        for (int i = 0; i < n; i++) v[8 * i +: 8] = ref_byte(a + 32'(i));
        if (sg && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
        if (sg && n == 2 && v[15]) v = v | 32'hFFFF_0000;
        last_rd = v;
      end else begin
        for (int i = 0; i < n; i++) ref_mem[a + 32'(i)] = wd[8 * i +: 8];
      end
      r.rdata  = last_rd;
      r.chk_rd = 1'b1;
    end
  endtask

  // Done monitor plus memory responder with random wait states and stray acks
  bit in_xfer = 1'b0;
  bit prev_req = 1'b0;
  int wleft = 0;
  always @(negedge clk) begin
    res_t r;
    txn_t t;
    logic [31:0] w;
    if (!rst) begin
      chk("err_only_with_done", 32'(err & ~done), 32'd0);
      if (done) begin
        obs_rdata = rdata;
        obs_err   = err;
        if (res_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_done act=1 exp=0 (cyc %0d)", cyc);
        end else begin
          r = res_q.pop_front();
          chk("err", 32'(err), 32'(r.err));
          if (r.chk_rd) chk("rdata", rdata, r.rdata);
          chk("latency", 32'(cyc - r.acc_cyc),
              32'(r.err ? 1 : 1 + r.nwords + (tot_waits - r.w_base)));
          chk("xfer_count", 32'(tot_acks - r.a_base), 32'(r.nwords));
          chk("busy_at_done", 32'(busy), 32'd1);
          chk("req_low_at_done", 32'(mem_if.mem_req), 32'd0);
        end
      end
    end
    if (mem_if.mem_req === 1'b1) begin
      if (!prev_req && res_q.size() != 0) chk("req_start", 32'(cyc), 32'(res_q[0].acc_cyc + 1));
      if (!in_xfer) begin
        in_xfer = 1'b1;
        wleft = (force_waits >= 0) ? force_waits : $urandom_range(0, 3);
      end
      if (txn_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_req act=%h exp=none (cyc %0d)", mem_if.mem_addr, cyc);
        mem_if.mem_ack = 1'b0;
      end else begin
        t = txn_q[0];
        chk("mem_addr", mem_if.mem_addr, t.a);
        chk("mem_be", 32'(mem_if.mem_be), 32'(t.be));
        chk("mem_we", 32'(mem_if.mem_we), 32'(t.we));
        if (t.we) chk("mem_wdata", mem_if.mem_wdata, t.wd);
        if (wleft == 0 && !hold_ack) begin
          w = rd_word(t.a);
          mem_if.mem_rdata = w;
          if (t.we) begin
            for (int l = 0; l < 4; l++) if (t.be[l]) w[8 * l +: 8] = t.wd[8 * l +: 8];
            resp_mem[t.a] = w;
          end
          mem_if.mem_ack = 1'b1;
          void'(txn_q.pop_front());
          in_xfer = 1'b0;
          tot_acks++;
        end else begin
          if (wleft > 0) wleft--;
          mem_if.mem_ack = 1'b0;
          mem_if.mem_rdata = $urandom;
          tot_waits++;
        end
      end
    end else begin
      in_xfer = 1'b0;
      mem_if.mem_ack = ($urandom_range(0, 3) == 0);
      mem_if.mem_rdata = $urandom;
    end
    prev_req = (mem_if.mem_req === 1'b1);
  end

  // Issue one op at posedge+1 with the DUT idle; returns at posedge+1 after FIN
  task automatic do_op(input bit rd, input logic [3:0] wr, input logic [1:0] sz, input bit sg,
                       input logic [31:0] a, input logic [31:0] wd, input int waits);
    res_t r;
    bit got;
    force_waits = waits;
    model(rd, wr, sz, sg, a, wd, r);
    res_q.push_back(r);
    req_valid = 1'b1; mem_read = rd; mem_write = wr; read_size = sz;
    read_signed = sg; addr = a; wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'($urandom); mem_read = 1'($urandom); mem_write = 4'($urandom);
    read_size = 2'($urandom); read_signed = 1'($urandom); addr = $urandom; wdata = $urandom;
    got = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (i == 0) chk("busy_after_accept", 32'(busy), 32'd1);
      if (done) begin got = 1'b1; break; end
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL op_timeout act=no_done exp=done (cyc %0d)", cyc);
      res_q.delete(); txn_q.delete();
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      req_valid = 1'b1; mem_read = 1'b0; mem_write = 4'h0; addr = $urandom;
      @(negedge clk);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_req", 32'(mem_if.mem_req), 32'd0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    res_t r;
    bit rd;
    logic [3:0] wr;
    logic [1:0] sz;
    logic [31:0] a;
    rst = 1'b1; req_valid = 1'b0; mem_read = 1'b0; mem_write = 4'h0; read_size = 2'd0;
    read_signed = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_req", 32'(mem_if.mem_req), 32'd0);
    chk("rst_we", 32'(mem_if.mem_we), 32'd0);
    chk("rst_be", 32'(mem_if.mem_be), 32'd0);
    chk("rst_addr", mem_if.mem_addr, 32'd0);
    chk("rst_wdata", mem_if.mem_wdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_gap(2);

    // Aligned SW, zero wait
    do_op(1'b0, 4'hF, 2'd0, 1'b0, 32'h100, 32'hDEAD_BEEF, 0);
    chk("sw_err", 32'(obs_err), 32'd0);
    // LB signed with two wait states
    preload(32'h200, 32'h80FF_FFFF);
    do_op(1'b1, 4'h0, 2'd0, 1'b1, 32'h203, 32'h0, 2);
    chk("lb_signed_rdata", obs_rdata, 32'hFFFF_FF80);
    // LHU crossing a word boundary
    preload(32'h0FC, 32'hAB00_0000);
    preload(32'h100, 32'h0000_00CD);
    do_op(1'b1, 4'h0, 2'd1, 1'b0, 32'h0FF, 32'h0, 0);
`ifdef LSU_MISALIGN_SPLIT_EN
    chk("lhu_split_rdata", obs_rdata, 32'h0000_CDAB);
`else
    chk("lhu_split_err", 32'(obs_err), 32'd1);
`endif
    // SH crossing a word boundary, back to back
    do_op(1'b0, 4'h3, 2'd0, 1'b0, 32'h13, 32'h0000_1234, 0);
    do_op(1'b1, 4'h0, 2'd1, 1'b0, 32'h13, 32'h0, 1);
    // Illegal ops
    do_op(1'b1, 4'h3, 2'd1, 1'b0, 32'h40, 32'h0, 0);
    chk("ill_rw_err", 32'(obs_err), 32'd1);
    do_op(1'b1, 4'h0, 2'd3, 1'b0, 32'h40, 32'h0, 0);
    chk("ill_size3_err", 32'(obs_err), 32'd1);
    do_op(1'b0, 4'h7, 2'd0, 1'b0, 32'h40, 32'h0, 0);
    chk("ill_pattern_err", 32'(obs_err), 32'd1);
    do_op(1'b1, 4'h0, 2'd2, 1'b0, 32'h2, 32'h0, 0);
`ifdef LSU_MISALIGN_SPLIT_EN
    chk("lw_off2_err", 32'(obs_err), 32'd0);
`else
    chk("lw_off2_err", 32'(obs_err), 32'd1);
`endif
    // Address wrap at the top of the space
    do_op(1'b0, 4'hF, 2'd0, 1'b0, 32'hFFFF_FFFD, 32'h1122_3344, 1);
    do_op(1'b1, 4'h0, 2'd1, 1'b1, 32'hFFFF_FFFF, 32'h0, 0);

    // Reset during ACC0 with the ack withheld
    hold_ack = 1'b1;
    force_waits = 0;
    model(1'b1, 4'h0, 2'd2, 1'b0, 32'h80, 32'h0, r);
    res_q.push_back(r);
    req_valid = 1'b1; mem_read = 1'b1; mem_write = 4'h0; read_size = 2'd2; addr = 32'h80;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    res_q.delete(); txn_q.delete();
    hold_ack = 1'b0; last_rd = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rstmid_req", 32'(mem_if.mem_req), 32'd0);
      chk("rstmid_busy", 32'(busy), 32'd0);
      chk("rstmid_done", 32'(done), 32'd0);
    end
    @(posedge clk); #1;
    do_op(1'b1, 4'h0, 2'd2, 1'b0, 32'h40, 32'h0, 0);
    chk("lw_after_rst_err", 32'(obs_err), 32'd0);

    // Randomized ops over a small address window plus the top of memory
    for (int k = 0; k < 250; k++) begin
      rd = 1'($urandom);
      case ($urandom_range(0, 9))
        0:       wr = 4'($urandom);
        1, 2, 3: wr = 4'h1;
        4, 5, 6: wr = 4'h3;
        default: wr = 4'hF;
      endcase
      if (rd && $urandom_range(0, 9) < 8) wr = 4'h0;
      if (!rd && wr == 4'h0) rd = 1'b1;
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      case ($urandom_range(0, 2))
        0:       a = 32'h0000_0000;
        1:       a = 32'h0000_1000;
        default: a = 32'hFFFF_FFC0;
      endcase
      a = a | 32'($urandom_range(0, 63));
      do_op(rd, wr, sz, 1'($urandom), a, $urandom, -1);
      if ($urandom_range(0, 3) == 0) idle_gap($urandom_range(1, 2));
    end

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 32'(res_q.size() + txn_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
